de2_70_nios_mul_seq: RTL



---
 rtl/de2_70_nios_mul_seq_pkg.sv | 10 +
 rtl/de2_70_nios_mul_seq_mult16.sv | 25 ++
 rtl/de2_70_nios_mul_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/de2_70_nios_mul_seq_pkg.sv
// de2_70_nios_mul_seq_pkg: opcodes, FSM states and datapath widths for the multiply sequencer.
package de2_70_nios_mul_seq_pkg;
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;
    localparam int HALF_W = 16;
    localparam int ACC_W  = 64;
    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;
endpackage

// File: rtl/de2_70_nios_mul_seq_mult16.sv
// de2_70_nios_mul_seq_mult16: 16x16 unsigned multiplier with LAT register stages and sync clear.
module de2_70_nios_mul_seq_mult16
    import de2_70_nios_mul_seq_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);
    logic [2*HALF_W-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[LAT-1];
endmodule

// File: rtl/de2_70_nios_mul_seq.sv
// de2_70_nios_mul_seq: 32x32 multiply sequencer sharing one pipelined 16x16 multiplier.
// Optional DE2_70_NIOS_MUL_SEQ_FAST_LO_EN: MUL skips pp3 and the sign fix-up.
module de2_70_nios_mul_seq
    import de2_70_nios_mul_seq_pkg::*;
#(
    parameter int MULT_LATENCY = 1,
    parameter int OP_W         = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_src1,
    input  logic [31:0]     in_src2,
    input  logic [OP_W-1:0] in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic            busy
);
    state_t state, state_nxt;
    logic [31:0] a, b, corr;
    logic [OP_W-1:0] op;
    logic [ACC_W-1:0] acc, pp_ext;
    logic [2:0] cnt;
    logic [2:0] tag [MULT_LATENCY];
    logic [HALF_W-1:0] ma, mb;
    logic [2*HALF_W-1:0] prod;
    logic [1:0] sh;
    logic issue, last, fast, sign_a, sign_b;

`ifdef DE2_70_NIOS_MUL_SEQ_FAST_LO_EN
    assign fast = op == OP_MUL;
`else
    assign fast = 1'b0;
`endif

    de2_70_nios_mul_seq_mult16 #(.LAT(MULT_LATENCY)) u_mult (
        .clk(clk), .reset(reset), .a(ma), .b(mb), .p(prod)
    );

    // cnt[0] picks the A half, cnt[1] the B half; shift in units of 16 bits
    always_comb begin
        ma = cnt[0] ? a[31:16] : a[15:0];
        mb = cnt[1] ? b[31:16] : b[15:0];
        sh = {1'b0, cnt[0]} + {1'b0, cnt[1]};
        issue = state == MUL && cnt < (fast ? 3'd3 : 3'd4);
        last = state == MUL && cnt == (fast ? 3'(MULT_LATENCY + 2) : 3'(MULT_LATENCY + 3));
        pp_ext = {32'b0, prod} << {tag[MULT_LATENCY-1][1:0], 4'b0};
        sign_a = op == OP_MULXSU || op == OP_MULXSS;
        sign_b = op == OP_MULXSS;
        corr = (sign_a && a[31] ? b : 32'd0) + (sign_b && b[31] ? a : 32'd0);
        state_nxt = state;
        case (state)
            IDLE: state_nxt = in_valid && in_ready ? MUL : IDLE;
            MUL:  state_nxt = last ? (fast ? DONE : FIX) : MUL;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            a <= '0;
            b <= '0;
            op <= '0;
            for (int i = 0; i < MULT_LATENCY; i++) tag[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt <= state == MUL ? cnt + 3'd1 : 3'd0;
            tag[0] <= {issue, sh};
            for (int i = 1; i < MULT_LATENCY; i++) tag[i] <= tag[i-1];
            if (state == IDLE && in_valid) begin
                a <= in_src1;
                b <= in_src2;
                op <= in_op;
                acc <= '0;
            end
            if (state == MUL && tag[MULT_LATENCY-1][2]) acc <= acc + pp_ext;
            if (state == FIX) acc[63:32] <= acc[63:32] - corr;
        end
    end

    assign in_ready = state == IDLE && !reset;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign out_result = state != DONE ? 32'd0 : op == OP_MUL ? acc[31:0] : acc[63:32];
endmodule
